// File: rtl/button_debounce_sync.sv
// Push-button conditioner: a two-flop synchronizer feeds a debounce FSM.
// The FSM produces a clean level, one-cycle rise/fall pulses and a count of rises.
module button_debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       preset,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_rise,
    output logic       btn_fall,
    output logic [7:0] rise_count
);

    // state     | meaning
    // STABLE_LO | clean level 0, no candidate change
    // WAIT_HI   | level 0, counting consecutive high samples
    // STABLE_HI | clean level 1, no candidate change
    // WAIT_LO   | level 1, counting consecutive low samples
    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync1, sync2;
    logic             rise_nxt, fall_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (sync2) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_nxt = STABLE_LO;
                end else if (cnt == CNT_TC) begin
                    state_nxt = STABLE_HI;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_nxt = STABLE_HI;
                end else if (cnt == CNT_TC) begin
                    state_nxt = STABLE_LO;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = STABLE_LO;
        endcase
    end

    // Reset reloads everything from preset, discarding any pending transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= preset;
            sync2      <= preset;
            state      <= preset ? STABLE_HI : STABLE_LO;
            cnt        <= '0;
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            rise_count <= 8'd0;
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            btn_rise <= rise_nxt;
            btn_fall <= fall_nxt;
            if (rise_nxt) rise_count <= rise_count + 8'd1;
        end
    end

    assign btn_level = (state == STABLE_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_button_debounce_sync.sv
// Bench for button_debounce_sync: directed table, corner sequences and
// randomized stimulus against a sliding-window reference model.
module tb_button_debounce_sync;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       preset = 1'b0;
    logic       btn_in = 1'b0;
    logic       btn_level, btn_rise, btn_fall;
    logic [7:0] rise_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rise_seen = 0;
    int n_fall_seen = 0;

    // Reference model: synchronizer as a 2-deep delay, level flips when the
    // last S samples seen by the debouncer all differ from the current level.
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    logic [7:0] m_rc = 8'd0;
    logic       win[$];

    button_debounce_sync #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .preset(preset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
        .rise_count(rise_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic p, input logic b);
        logic seen;
        logic all_diff;
        if (!r) begin
            m_s1 = p; m_s2 = p; m_lvl = p;
            m_rise = 1'b0; m_fall = 1'b0; m_rc = 8'd0;
            win.delete();
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            win.push_back(seen);
            if (win.size() > S) void'(win.pop_front());
            m_rise = 1'b0;
            m_fall = 1'b0;
            all_diff = (win.size() == S);
            foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl  = ~m_lvl;
                m_rise = m_lvl;
                m_fall = ~m_lvl;
                if (m_rise) m_rc = m_rc + 8'd1;
                win.delete();
            end
        end
    endtask

    // One clock: drive on negedge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic p, input logic b);
        @(negedge clk);
        rst = r; preset = p; btn_in = b;
        @(posedge clk);
        #1;
        model_edge(r, p, b);
        if (btn_rise) n_rise_seen++;
        if (btn_fall) n_fall_seen++;
        check("model_level", btn_level, m_lvl);
        check("model_rise", btn_rise, m_rise);
        check("model_fall", btn_fall, m_fall);
        check("model_rise_count", rise_count, m_rc);
        check("rise_fall_exclusive", btn_rise & btn_fall, 0);
    endtask

    typedef struct {
        logic       r, p, b;
        logic       lvl, rise, fall;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int rises_before;
        logic cur;
        int   hold;
        logic pat[5];

        // Edge index == table index; btn_in first sampled high at edge 10.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 7; i < 10; i++)  tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 10; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].p, tbl[i].b);
            check($sformatf("tbl%0d_level", i), btn_level, tbl[i].lvl);
            check($sformatf("tbl%0d_rise", i), btn_rise, tbl[i].rise);
            check($sformatf("tbl%0d_fall", i), btn_fall, tbl[i].fall);
            check($sformatf("tbl%0d_rise_count", i), rise_count, tbl[i].rc);
        end

        // Release from level 1: fall pulse exactly 5 edges after first low sample.
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("fall_seq%0d_level", j), btn_level, (j < 5) ? 1 : 0);
            check($sformatf("fall_seq%0d_fall", j), btn_fall, (j == 5) ? 1 : 0);
            check($sformatf("fall_seq%0d_rise_count", j), rise_count, 1);
        end

        // Bouncing press 1,0,1,0,1 then held: only the final run of highs counts.
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rises_before = n_rise_seen;
        for (int j = 0; j < 13; j++) begin
            step(1'b1, 1'b0, (j < 5) ? pat[j] : 1'b1);
            check($sformatf("bounce%0d_level", j), btn_level, (j >= 9) ? 1 : 0);
            check($sformatf("bounce%0d_rise", j), btn_rise, (j == 9) ? 1 : 0);
        end
        check("bounce_single_rise", n_rise_seen - rises_before, 1);
        check("bounce_rise_count", rise_count, 2);
        for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b0);
        check("bounce_release_level", btn_level, 0);

        // Reset arriving while a rise is pending (counter at 2) discards it.
        for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b1);
        check("pend_level_before_rst", btn_level, 0);
        step(1'b0, 1'b0, 1'b0);
        check("pend_rst_level", btn_level, 0);
        check("pend_rst_rise", btn_rise, 0);
        check("pend_rst_count", rise_count, 0);
        rises_before = n_rise_seen;
        for (int j = 0; j < 6; j++) step(1'b1, 1'b0, 1'b0);
        check("pend_no_rise_after", n_rise_seen - rises_before, 0);
        check("pend_level_after", btn_level, 0);

        // 256 clean press/release cycles: counter wraps back to zero.
        n_rise_seen = 0;
        n_fall_seen = 0;
        for (int c = 0; c < 256; c++) begin
            for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b1);
            for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b0);
        end
        check("wrap_rise_pulses", n_rise_seen, 256);
        check("wrap_fall_pulses", n_fall_seen, 256);
        check("wrap_rise_count", rise_count, 0);

        // Randomized bouncing with occasional resets, checked by the model in step().
        cur = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199, 0) == 0) begin
                step(1'b0, 1'($urandom_range(1, 0)), cur);
            end else begin
                if (hold == 0) begin
                    cur  = 1'($urandom_range(1, 0));
                    hold = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 5) : $urandom_range(4, 1);
                end
                hold--;
                step(1'b1, preset, cur);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
